// File: rtl/prbs_pkg.sv
// Shared PRBS31 definitions: polynomial taps, word width, line state and the
// word-parallel sequence step used by both the generator and the checker.
package prbs_pkg;

  localparam int WORD_W = 32;
  localparam int TAP_A  = 31;
  localparam int TAP_B  = 28;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Bit 31 is earliest; bits 3..0 depend on bits generated earlier in this word.
  function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] prev);
    logic [2*WORD_W-1:0] seq;
    seq = {prev, {WORD_W{1'b0}}};
    for (int i = WORD_W - 1; i >= 0; i--) begin
      seq[i] = seq[i+TAP_A] ^ seq[i+TAP_B];
    end
    return seq[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Receive-side PRBS word stream plus checker status/counter outputs.
interface prbs_checker_if;
  import prbs_pkg::*;

  logic [WORD_W-1:0] data_in;
  logic              data_valid;
  logic              clear_counts;
  logic              locked;
  logic              err_word;
  logic [31:0]       bit_err_count;
  logic [31:0]       word_err_count;

  modport master (
    output data_in, data_valid, clear_counts,
    input  locked, err_word, bit_err_count, word_err_count
  );

  modport slave (
    input  data_in, data_valid, clear_counts,
    output locked, err_word, bit_err_count, word_err_count
  );

endinterface

// File: rtl/popcount32.sv
// Number of set bits in a 32-bit word, built as a balanced adder tree.
module popcount32 (
  input  logic [31:0] value,
  output logic [5:0]  count
);

  logic [1:0] sum1 [16];
  logic [2:0] sum2 [8];
  logic [3:0] sum3 [4];
  logic [4:0] sum4 [2];

  always_comb begin
    for (int i = 0; i < 16; i++) sum1[i] = {1'b0, value[2*i]} + {1'b0, value[2*i+1]};
    for (int i = 0; i < 8; i++)  sum2[i] = {1'b0, sum1[2*i]} + {1'b0, sum1[2*i+1]};
    for (int i = 0; i < 4; i++)  sum3[i] = {1'b0, sum2[2*i]} + {1'b0, sum2[2*i+1]};
    for (int i = 0; i < 2; i++)  sum4[i] = {1'b0, sum3[2*i]} + {1'b0, sum3[2*i+1]};
    count = {1'b0, sum4[0]} + {1'b0, sum4[1]};
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS31 word checker: self-synchronises on the incoming stream, then compares
// against a free-running local LFSR and accumulates saturating error counts.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          reset,
  prbs_checker_if.slave bus
);

  localparam logic [3:0] LOCK_LIM   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_LIM = 4'(UNLOCK_CNT);

  state_t            state, state_d;
  logic              have_prev, have_prev_d;
  logic [3:0]        match_cnt, match_d;
  logic [3:0]        bad_cnt, bad_d;
  logic [WORD_W-1:0] prev_word, prev_d;
  logic [WORD_W-1:0] lfsr, lfsr_d;
  logic [WORD_W-1:0] exp_word, pred_word, diff;
  logic [5:0]        errs;
  logic              err_word_q, err_word_d;
  logic [31:0]       bit_err_cnt, bit_d;
  logic [31:0]       word_err_cnt, word_d;
  logic [32:0]       bit_sum;

  assign exp_word  = next_word(lfsr);
  assign pred_word = next_word(prev_word);
  assign diff      = bus.data_in ^ exp_word;
  assign bit_sum   = {1'b0, bit_err_cnt} + {27'd0, errs};

  popcount32 u_popcount (
    .value (diff),
    .count (errs)
  );

  always_comb begin
    state_d     = state;
    have_prev_d = have_prev;
    match_d     = match_cnt;
    bad_d       = bad_cnt;
    prev_d      = prev_word;
    lfsr_d      = lfsr;
    err_word_d  = 1'b0;
    bit_d       = bit_err_cnt;
    word_d      = word_err_cnt;

    if (bus.data_valid) begin
      unique case (state)
        SEARCH: begin
          prev_d      = bus.data_in;
          have_prev_d = 1'b1;
          // An all-zero line is a valid LFSR fixed point, so it must never lock.
          if (have_prev && bus.data_in == pred_word && bus.data_in != '0) begin
            match_d = match_cnt + 4'd1;
            if (match_d == LOCK_LIM) begin
              state_d = LOCKED;
              lfsr_d  = bus.data_in;
              bad_d   = 4'd0;
            end
          end else begin
            match_d = 4'd0;
          end
        end
        LOCKED: begin
          lfsr_d = exp_word;
          if (errs != 6'd0) begin
            err_word_d = 1'b1;
            bit_d      = bit_sum[32] ? '1 : bit_sum[31:0];
            word_d     = (word_err_cnt == '1) ? '1 : word_err_cnt + 32'd1;
            bad_d      = bad_cnt + 4'd1;
            if (bad_d == UNLOCK_LIM) begin
              state_d     = SEARCH;
              match_d     = 4'd0;
              prev_d      = bus.data_in;
              have_prev_d = 1'b1;
            end
          end else begin
            bad_d = 4'd0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (bus.clear_counts) begin
      bit_d  = '0;
      word_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SEARCH;
      have_prev    <= 1'b0;
      match_cnt    <= 4'd0;
      bad_cnt      <= 4'd0;
      prev_word    <= '0;
      lfsr         <= '0;
      err_word_q   <= 1'b0;
      bit_err_cnt  <= '0;
      word_err_cnt <= '0;
    end else begin
      state        <= state_d;
      have_prev    <= have_prev_d;
      match_cnt    <= match_d;
      bad_cnt      <= bad_d;
      prev_word    <= prev_d;
      lfsr         <= lfsr_d;
      err_word_q   <= err_word_d;
      bit_err_cnt  <= bit_d;
      word_err_cnt <= word_d;
    end
  end

  assign bus.locked         = (state == LOCKED);
  assign bus.err_word       = err_word_q;
  assign bus.bit_err_count  = bit_err_cnt;
  assign bus.word_err_count = word_err_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: directed PRBS31 streams from a bit-serial
// reference generator, expectations queued per valid word and checked by a monitor.
module tb_prbs_checker;

  typedef struct {
    bit          chk_lk;
    bit          lk;
    bit          chk_ew;
    bit          ew;
    bit          chk_cnt;
    logic [31:0] bc;
    logic [31:0] wc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  prbs_checker_if bus ();

  prbs_checker #(
    .LOCK_CNT   (4),
    .UNLOCK_CNT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [30:0] hist;

  // Reference generator: one sequence bit at a time, hist[0] is the newest bit.
  function automatic logic [31:0] genWord();
    logic [31:0] w;
    logic        nb;
    w = '0;
    for (int b = 31; b >= 0; b--) begin
      nb   = hist[30] ^ hist[27];
      w[b] = nb;
      hist = {hist[29:0], nb};
    end
    return w;
  endfunction

  function automatic exp_t mkExp(input string n, input bit cl, input bit l, input bit ce,
                                 input bit ew, input bit cc, input logic [31:0] bc,
                                 input logic [31:0] wc);
    exp_t e;
    e.name = n; e.chk_lk = cl; e.lk = l; e.chk_ew = ce; e.ew = ew;
    e.chk_cnt = cc; e.bc = bc; e.wc = wc;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w, input logic v, input logic clr, input exp_t e);
    @(negedge clk);
    bus.data_in      = w;
    bus.data_valid   = v;
    bus.clear_counts = clr;
    if (v) sb.push_back(e);
  endtask

  task automatic drain();
    applyStimulus(32'h0, 1'b0, 1'b0, mkExp("idle", 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0 pending entries", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every sampled valid word produces one registered response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (reset && bus.data_valid) begin
        #1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL sb_underflow actual=empty required=entry");
        end else begin
          e = sb.pop_front();
          if (e.chk_lk)  checkOutput({e.name, "_locked"}, {31'd0, bus.locked}, {31'd0, e.lk});
          if (e.chk_ew)  checkOutput({e.name, "_err_word"}, {31'd0, bus.err_word}, {31'd0, e.ew});
          if (e.chk_cnt) begin
            checkOutput({e.name, "_bit_cnt"}, bus.bit_err_count, e.bc);
            checkOutput({e.name, "_word_cnt"}, bus.word_err_count, e.wc);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    bus.data_in      = '0;
    bus.data_valid   = 1'b0;
    bus.clear_counts = 1'b0;
    reset            = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_locked", {31'd0, bus.locked}, 32'd0);
    checkOutput("rst_err_word", {31'd0, bus.err_word}, 32'd0);
    checkOutput("rst_bit_cnt", bus.bit_err_count, 32'd0);
    checkOutput("rst_word_cnt", bus.word_err_count, 32'd0);
    reset = 1'b1;

    $display("[TB] clean stream from seed 0x7FFFFFFF");
    hist = 31'h7FFFFFFF;
    for (int k = 1; k <= 1000; k++) begin
      w = (k == 1) ? 32'h7FFFFFFF : genWord();
      applyStimulus(w, 1'b1, 1'b0, mkExp("clean", 1, k >= 5, 1, 0, 1, 0, 0));
    end

    $display("[TB] two-bit error word");
    applyStimulus(genWord() ^ 32'h80000001, 1'b1, 1'b0, mkExp("flip2", 1, 1, 1, 1, 1, 2, 1));
    applyStimulus(genWord(), 1'b1, 1'b0, mkExp("after_flip", 1, 1, 1, 0, 1, 2, 1));

    $display("[TB] unlock on four fully corrupted words");
    applyStimulus(genWord(), 1'b1, 1'b1, mkExp("clear", 1, 1, 1, 0, 1, 0, 0));
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(genWord() ^ 32'hFFFFFFFF, 1'b1, 1'b0,
                    mkExp("corrupt", 1, k < 4, 1, 1, 1, 32 * k, k));
    end
    // First clean word mismatches next_word(~last), so lock needs five clean words.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(genWord(), 1'b1, 1'b0, mkExp("relock", 1, k == 5, 1, 0, 1, 128, 4));
    end

    $display("[TB] clear_counts with an errored word");
    applyStimulus(genWord() ^ 32'h00010000, 1'b1, 1'b1, mkExp("clr_err", 1, 1, 0, 0, 1, 0, 0));
    applyStimulus(genWord(), 1'b1, 1'b0, mkExp("post_clr", 1, 1, 1, 0, 1, 0, 0));

    $display("[TB] counter saturation");
    drain();
    @(negedge clk);
    force dut.bit_err_cnt  = 32'hFFFFFFF0;
    force dut.word_err_cnt = 32'hFFFFFFFF;
    #1;
    release dut.bit_err_cnt;
    release dut.word_err_cnt;
    applyStimulus(genWord() ^ 32'hFFFFFFFF, 1'b1, 1'b0,
                  mkExp("saturate", 1, 1, 1, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF));
    applyStimulus(genWord(), 1'b1, 1'b0,
                  mkExp("sat_hold", 1, 1, 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF));
    drain();

    $display("[TB] async reset mid-word");
    @(negedge clk);
    bus.data_in    = genWord();
    bus.data_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_locked", {31'd0, bus.locked}, 32'd0);
    checkOutput("arst_err_word", {31'd0, bus.err_word}, 32'd0);
    checkOutput("arst_bit_cnt", bus.bit_err_count, 32'd0);
    checkOutput("arst_word_cnt", bus.word_err_count, 32'd0);
    bus.data_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    $display("[TB] all-zero line");
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(32'h0, 1'b1, 1'b0, mkExp("zeros", 1, 0, 1, 0, 1, 0, 0));
    end
    drain();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] data_valid toggling on a clean stream");
    hist = 31'h7FFFFFFF;
    for (int k = 1; k <= 10; k++) begin
      w = (k == 1) ? 32'h7FFFFFFF : genWord();
      applyStimulus(w, 1'b1, 1'b0, mkExp("toggle", 1, k >= 5, 1, 0, 1, 0, 0));
      applyStimulus(32'hDEADBEEF, 1'b0, 1'b0, mkExp("gap", 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      checkOutput("gap_err_word", {31'd0, bus.err_word}, 32'd0);
      checkOutput("gap_locked", {31'd0, bus.locked}, {31'd0, k >= 5});
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Word-parallel PRBS31 receiver/checker: the receive-side counterpart of the block-level PRNG, which produces a 32-bit pseudo-random word per clock. Self-synchronises to an incoming 32-bit PRBS31 word stream, declares lock after consecutive error-free predictions, then free-runs a local LFSR and counts bit and word errors against it. Sits at the far end of a link or loopback under test and feeds status/counters to the GUI register map.

## Interface
- LOCK_CNT, 4, consecutive matching valid words required in SEARCH to enter LOCKED (1..15)
- UNLOCK_CNT, 4, consecutive errored valid words in LOCKED that force return to SEARCH (1..15)
- clk  in  1  rising-edge clock, single domain
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- data_in  in  32  received PRBS word; bit 31 is the earliest bit in sequence order
- data_valid  in  1  data_in is sampled only when 1
- clear_counts  in  1  synchronous clear of bit_err_count and word_err_count
- locked  out  1  1 while in LOCKED state
- err_word  out  1  one-cycle pulse: last valid word in LOCKED had ≥1 bit error
- bit_err_count  out  32  saturating count of errored bits while LOCKED
- word_err_count  out  32  saturating count of errored words while LOCKED

## Operation
- Sequence: s[n] = s[n-31] XOR s[n-28] (x^31 + x^28 + 1). next_word(w) = next 32 sequence bits given the previous 32 bits w, computed bit-serially from bit 31 down to 0 (later bits use bits already generated in the same word); pure combinational function.
- States: SEARCH, LOCKED. Reset state SEARCH.
- SEARCH, per valid word:
  - no stored previous word (have_prev=0): store data_in as prev, set have_prev, match_cnt=0.
  - else match = (data_in == next_word(prev)) AND data_in != 0. match → match_cnt+1; otherwise match_cnt=0. prev <= data_in always.
  - match_cnt reaching LOCK_CNT → LOCKED, lfsr <= data_in, bad_cnt=0.
- LOCKED, per valid word:
  - exp = next_word(lfsr); lfsr <= exp (free-running, never reloaded from data).
  - errs = popcount(data_in XOR exp), 0..32.
  - errs≠0: err_word=1, bit_err_count += errs, word_err_count += 1 (each saturates at 0xFFFFFFFF), bad_cnt+1; errs=0: bad_cnt=0.
  - bad_cnt reaching UNLOCK_CNT → SEARCH, match_cnt=0, prev <= data_in, have_prev=1. The counts for that final word are still accumulated.
- data_valid=0: no state, LFSR, or counter change; err_word=0.
- All-zero words never match in SEARCH (dead-line protection).
- clear_counts has priority over same-cycle accumulation: counters go to 0 and the current word's errors are discarded. Lock state is unaffected.

## Timing
- Reset values: locked=0, err_word=0, bit_err_count=0, word_err_count=0, state SEARCH, have_prev=0, match_cnt=0, bad_cnt=0, prev=0, lfsr=0.
- All outputs are registered, updated on the clk edge that samples the word; latency is one cycle from valid word to output.
- Lock: a clean stream with data_valid held high gives locked=1 after the edge sampling valid word LOCK_CNT+1 (word 1 only loads prev).
- Unlock: locked=0 after the edge sampling the UNLOCK_CNT-th consecutive errored word.
- Reset assertion mid-stream clears everything immediately, without waiting for clk; relock restarts from have_prev=0.

## Structure
- Package prbs_pkg: PRBS31 taps (31, 28), word width 32, next_word function, state enum {SEARCH, LOCKED}. The PRNG generator shares these.
- Sub-module popcount32 (32-bit in, 6-bit out), combinational adder tree.
- The FSM, LFSR, and saturating counters live in prbs_checker.

## Test plan
- Reset, then clean PRBS31 from seed 0x7FFFFFFF, data_valid=1 → locked=1 after the 5th sampled word; both counts stay 0 over 1000 words.
- Locked; flip bits 0 and 31 of one word → err_word pulses once, bit_err_count=2, word_err_count=1, locked stays 1, and the next word is clean (LFSR not corrupted).
- Locked; 4 consecutive all-ones-XOR-corrupted words → locked=0 after the 4th; bit_err_count=128, word_err_count=4; clean stream resumes → relock after 4 further matching words.
- All-zero input for 20 valid words → locked never asserts.
- data_valid toggled 1/0 every cycle on a clean stream → locks after 5 valid words; gaps cause no errors.
- Preload bit_err_count near 0xFFFFFFF0 via a long errored run (force), then a 32-bit error word → saturates at 0xFFFFFFFF. clear_counts in the same cycle as an errored word → counts read 0. Async reset asserted mid-word → all outputs 0 before the next clk edge.
